// File: rtl/c1541_track_sched.sv
// c1541_track_sched: multi-drive SD half-track sequencer.
// Dirty write-back, metadata reload and wrapped track reads.
module c1541_track_sched #(
  parameter int DRIVES    = 2,
  parameter int LBAS      = 16,
  parameter int META_LBAS = 2,
  parameter int HALF_TRKS = 84,
  localparam int LW = $clog2(LBAS),
  localparam int SW = (DRIVES > 1) ? $clog2(DRIVES) : 1
) (
  input  logic                 sd_clk,
  input  logic                 reset,
  input  logic [7*DRIVES-1:0]  req_trk,
  input  logic [LW*DRIVES-1:0] req_start,
  input  logic [DRIVES-1:0]    dirty,
  input  logic [DRIVES-1:0]    disk_change,
  output logic [7*DRIVES-1:0]  cur_trk,
  output logic [DRIVES-1:0]    busy,
  output logic [DRIVES-1:0]    done,
  output logic [SW-1:0]        sel,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  output logic                 meta
);

  localparam int CW = LW + 1;
  localparam logic [CW-1:0] C_LBAS1 = CW'(LBAS - 1);
  localparam logic [CW-1:0] C_META1 = CW'(META_LBAS - 1);
  localparam logic [6:0]    C_MTRK  = 7'(HALF_TRKS);
  localparam logic [6:0]    C_MAXT  = 7'(HALF_TRKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_WB, S_META, S_LOAD, S_FIN
  } state_t;

  typedef enum logic [1:0] {
    P_REQ, P_ACK, P_GAP
  } ph_t;

  state_t r_state, w_next;
  ph_t    r_ph;

  logic [6:0]        r_cur [DRIVES];
  logic [DRIVES-1:0] r_need_meta;
  logic [DRIVES-1:0] r_need_load;
  logic [DRIVES-1:0] r_need_wb;
  logic [SW-1:0]     r_sel;
  logic [SW-1:0]     r_rr;
  logic [LW-1:0]     r_lba;
  logic [CW-1:0]     r_cnt;
  logic              r_abort;
  logic              r_ack_blk;

  logic [6:0]          w_req   [DRIVES];
  logic [LW-1:0]       w_start [DRIVES];
  logic [DRIVES-1:0]   w_pend;
  logic [2*DRIVES-1:0] w_dbl;
  logic [SW-1:0]       w_pick;
  logic [SW-1:0]       w_rr_nx;
  logic [SW-1:0]       w_sel_n;
  logic                w_found;
  logic                w_xfer;
  logic                w_lba_done;
  logic                w_last;
  logic                w_mism;
  logic                w_abort;
  logic                w_wb_end;
  logic                w_enter;
  logic [6:0]          w_trk;

  // Per-drive request decode, clamping and status outputs
  always_comb begin
    for (int d = 0; d < DRIVES; d++) begin
      w_req[d] = (req_trk[7*d +: 7] >= C_MTRK) ? C_MAXT
                                               : req_trk[7*d +: 7];
      w_start[d] = req_start[LW*d +: LW];
      cur_trk[7*d +: 7] = r_cur[d];
      w_pend[d] = r_need_meta[d] | r_need_load[d] | r_need_wb[d];
      busy[d] = w_pend[d] |
                ((r_state != S_IDLE) && (r_sel == SW'(d)));
      done[d] = (r_state == S_FIN) && !r_abort &&
                (r_sel == SW'(d));
    end
  end

  // Round-robin pick: first pending drive at or after r_rr
  always_comb begin
    w_pick  = r_rr;
    w_found = 1'b0;
    w_dbl   = {w_pend, w_pend} >> r_rr;
    for (int i = 0; i < DRIVES; i++) begin
      if (!w_found && w_dbl[i]) begin
        w_found = 1'b1;
        w_pick  = SW'((int'(r_rr) + i) % DRIVES);
      end
    end
    w_rr_nx = SW'((int'(w_pick) + 1) % DRIVES);
  end

  // Transfer bookkeeping shared by all transfer states
  always_comb begin
    w_xfer = (r_state == S_WB) || (r_state == S_META) ||
             (r_state == S_LOAD);
    w_lba_done = w_xfer && (r_ph == P_ACK) && !sd_ack;
    w_last = (r_state == S_META) ? (r_cnt == C_META1)
                                 : (r_cnt == C_LBAS1);
    w_mism = w_req[r_sel] != r_cur[r_sel];
    w_abort = r_abort || ((r_state == S_LOAD) &&
              (w_mism || disk_change[r_sel]));
    w_wb_end = (r_state == S_WB) && w_lba_done &&
               (w_last || !r_need_wb[r_sel] || disk_change[r_sel]);
    w_sel_n = (r_state == S_ARB) ? w_pick : r_sel;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if ((|w_pend) && !r_ack_blk) w_next = S_ARB;
      end
      S_ARB: begin
        if (r_need_wb[w_pick])        w_next = S_WB;
        else if (r_need_meta[w_pick]) w_next = S_META;
        else                          w_next = S_LOAD;
      end
      S_WB: begin
        if (w_wb_end)
          w_next = (r_need_meta[r_sel] || disk_change[r_sel])
                   ? S_META : S_LOAD;
      end
      S_META: begin
        if (w_lba_done && w_last) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_lba_done && (w_last || w_abort)) w_next = S_FIN;
        else if ((r_ph == P_GAP) && w_abort)   w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_enter = (w_next != r_state) &&
              ((w_next == S_WB) || (w_next == S_META) ||
               (w_next == S_LOAD));
  end

  // SD port outputs
  always_comb begin
    sel    = r_sel;
    meta   = (r_state == S_META);
    sd_rd  = ((r_state == S_META) || (r_state == S_LOAD)) &&
             (r_ph == P_REQ);
    sd_wr  = (r_state == S_WB) && (r_ph == P_REQ);
    w_trk  = meta ? C_MTRK : r_cur[r_sel];
    sd_lba = '0;
    sd_lba[SW+7+LW-1:0] = {r_sel, w_trk, r_lba};
  end

  // State register
  always_ff @(posedge sd_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Datapath, handshake phase and pending flags
  always_ff @(posedge sd_clk) begin
    if (reset) begin
      r_sel       <= '0;
      r_rr        <= '0;
      r_lba       <= '0;
      r_cnt       <= '0;
      r_ph        <= P_GAP;
      r_abort     <= 1'b0;
      r_ack_blk   <= 1'b1;
      r_need_meta <= '0;
      r_need_load <= '0;
      r_need_wb   <= '0;
      for (int d = 0; d < DRIVES; d++) r_cur[d] <= 7'd36;
    end else begin
      if (!sd_ack) r_ack_blk <= 1'b0;
      if (r_state == S_ARB) begin
        r_sel   <= w_pick;
        r_rr    <= w_rr_nx;
        r_abort <= 1'b0;
      end else if (w_abort) begin
        r_abort <= 1'b1;
      end
      if (w_lba_done) begin
        r_lba <= r_lba + 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_enter) begin
        r_cnt <= '0;
        r_lba <= (w_next == S_META) ? '0 : w_start[w_sel_n];
        if (w_next == S_LOAD) r_cur[w_sel_n] <= w_req[w_sel_n];
      end
      if (r_state != w_next) begin
        r_ph <= P_GAP;
      end else if (w_xfer) begin
        unique case (r_ph)
          P_REQ:   if (sd_ack && !r_ack_blk) r_ph <= P_ACK;
          P_ACK:   if (!sd_ack) r_ph <= P_GAP;
          P_GAP:   r_ph <= P_REQ;
          default: r_ph <= P_GAP;
        endcase
      end
      for (int d = 0; d < DRIVES; d++) begin
        if ((r_state == S_FIN) && !r_abort && (r_sel == SW'(d)))
          r_need_load[d] <= 1'b0;
        if (w_wb_end && (r_sel == SW'(d)))
          r_need_wb[d] <= 1'b0;
        if ((r_state == S_META) && w_lba_done && w_last &&
            (r_sel == SW'(d)))
          r_need_meta[d] <= 1'b0;
        if (disk_change[d]) begin
          r_need_meta[d] <= 1'b1;
          r_need_load[d] <= 1'b1;
          r_need_wb[d]   <= 1'b0;
        end else if (w_req[d] != r_cur[d]) begin
          r_need_load[d] <= 1'b1;
          if (!r_need_load[d]) r_need_wb[d] <= dirty[d];
        end
      end
    end
  end

endmodule

// File: tb/tb_c1541_track_sched.sv
// tb_c1541_track_sched: directed bench for the track sequencer.
// Acts as the SD card and checks every issued LBA.
module tb_c1541_track_sched;

  logic        sd_clk = 1'b0;
  logic        reset;
  logic [13:0] req_trk;
  logic [7:0]  req_start;
  logic [1:0]  dirty;
  logic [1:0]  disk_change;
  logic [13:0] cur_trk;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic        sel;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        meta;

  int checks = 0;
  int errors = 0;
  int n_done [2] = '{0, 0};
  int n_ovl = 0;
  int n_strobe = 0;

  c1541_track_sched dut (
    .sd_clk(sd_clk), .reset(reset), .req_trk(req_trk),
    .req_start(req_start), .dirty(dirty),
    .disk_change(disk_change), .cur_trk(cur_trk), .busy(busy),
    .done(done), .sel(sel), .sd_lba(sd_lba), .sd_rd(sd_rd),
    .sd_wr(sd_wr), .sd_ack(sd_ack), .meta(meta)
  );

  always #5 sd_clk = ~sd_clk;

  always @(negedge sd_clk) begin
    if (sd_rd && sd_wr) n_ovl++;
    if (sd_rd || sd_wr) n_strobe++;
    for (int d = 0; d < 2; d++) if (done[d]) n_done[d]++;
  end

  function automatic logic [33:0] ex(bit w, bit m, int s, int t,
                                     int l);
    return {w, m, 32'((s << 11) | (t << 4) | (l % 16))};
  endfunction

  task automatic wait_strobe(output logic [33:0] got,
                             output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sd_clk);
      if (sd_rd || sd_wr) begin
        ok = 1'b1;
        break;
      end
    end
    got = {sd_wr, meta, sd_lba};
  endtask

  task automatic ack_lba;
    sd_ack = 1'b1;
    repeat (3) @(negedge sd_clk);
    sd_ack = 1'b0;
  endtask

  task automatic xfer(output logic [33:0] got, output bit ok);
    wait_strobe(got, ok);
    if (ok) ack_lba();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sd_clk);
      if (busy == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge sd_clk);
    checks++;
    if (busy !== 2'b00) begin
      errors++; $display("FAIL rst_busy got %b want 00", busy);
    end
    checks++;
    if (done !== 2'b00) begin
      errors++; $display("FAIL rst_done got %b want 00", done);
    end
    checks++;
    if ({sel, sd_rd, sd_wr, meta} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ctl got %b want 0000",
               {sel, sd_rd, sd_wr, meta});
    end
    checks++;
    if (cur_trk !== {7'd36, 7'd36}) begin
      errors++;
      $display("FAIL rst_trk got %h want %h", cur_trk,
               {7'd36, 7'd36});
    end
    reset = 1'b0;
    repeat (4) @(negedge sd_clk);
    checks++;
    if (busy !== 2'b00 || sd_rd !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet got %b%b want 000", busy, sd_rd);
    end
  endtask

  task automatic test_load;
    logic [33:0] got;
    bit ok;
    int d0;
    d0 = n_done[0];
    req_trk[6:0] = 7'd40;
    req_start[3:0] = 4'd5;
    for (int i = 0; i < 16; i++) begin
      xfer(got, ok);
      checks++;
      if (!ok || got !== ex(0, 0, 0, 40, 5 + i)) begin
        errors++;
        $display("FAIL load_lba%0d got %h want %h", i, got,
                 ex(0, 0, 0, 40, 5 + i));
        if (!ok) break;
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok || n_done[0] !== d0 + 1) begin
      errors++;
      $display("FAIL load_done got %0d want %0d", n_done[0], d0 + 1);
    end
    checks++;
    if (cur_trk[6:0] !== 7'd40) begin
      errors++;
      $display("FAIL load_cur got %0d want 40", cur_trk[6:0]);
    end
  endtask

  task automatic test_wb;
    logic [33:0] got;
    logic [33:0] exp;
    bit ok;
    int d1;
    d1 = n_done[1];
    n_ovl = 0;
    dirty[1] = 1'b1;
    req_trk[13:7] = 7'd38;
    req_start[7:4] = 4'd0;
    for (int i = 0; i < 32; i++) begin
      exp = (i < 16) ? ex(1, 0, 1, 36, i) : ex(0, 0, 1, 38, i);
      xfer(got, ok);
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL wb_seq%0d got %h want %h", i, got, exp);
        if (!ok) break;
      end
    end
    wait_idle(ok);
    dirty[1] = 1'b0;
    checks++;
    if (!ok || n_done[1] !== d1 + 1) begin
      errors++;
      $display("FAIL wb_done got %0d want %0d", n_done[1], d1 + 1);
    end
    checks++;
    if (n_ovl !== 0) begin
      errors++; $display("FAIL wb_overlap got %0d want 0", n_ovl);
    end
    checks++;
    if (cur_trk[13:7] !== 7'd38) begin
      errors++;
      $display("FAIL wb_cur got %0d want 38", cur_trk[13:7]);
    end
  endtask

  task automatic test_rr(input int t0, input int t1,
                         input bit first1);
    logic [33:0] got;
    logic [33:0] exp;
    bit ok;
    int a;
    int b;
    a = n_done[0];
    b = n_done[1];
    req_start = 8'h00;
    req_trk = {7'(t1), 7'(t0)};
    for (int i = 0; i < 32; i++) begin
      if ((i < 16) != first1) exp = ex(0, 0, 0, t0, i);
      else                    exp = ex(0, 0, 1, t1, i);
      xfer(got, ok);
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL rr%0d_seq%0d got %h want %h", first1, i,
                 got, exp);
        if (!ok) break;
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok || n_done[0] !== a + 1 || n_done[1] !== b + 1) begin
      errors++;
      $display("FAIL rr%0d_done got %0d/%0d want %0d/%0d", first1,
               n_done[0], n_done[1], a + 1, b + 1);
    end
  endtask

  task automatic test_meta;
    logic [33:0] got;
    logic [33:0] exp;
    bit ok;
    int d0;
    d0 = n_done[0];
    req_start[3:0] = 4'd3;
    disk_change[0] = 1'b1;
    @(negedge sd_clk);
    disk_change[0] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      exp = (i < 2) ? ex(0, 1, 0, 84, i) : ex(0, 0, 0, 44, 1 + i);
      xfer(got, ok);
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL meta_seq%0d got %h want %h", i, got, exp);
        if (!ok) break;
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok || n_done[0] !== d0 + 1) begin
      errors++;
      $display("FAIL meta_done got %0d want %0d", n_done[0], d0 + 1);
    end
  endtask

  task automatic test_abort;
    logic [33:0] got;
    bit ok;
    int d0;
    d0 = n_done[0];
    req_trk[6:0] = 7'd40;
    for (int i = 0; i < 3; i++) begin
      xfer(got, ok);
      checks++;
      if (!ok || got !== ex(0, 0, 0, 40, i)) begin
        errors++;
        $display("FAIL abort_pre%0d got %h want %h", i, got,
                 ex(0, 0, 0, 40, i));
      end
    end
    wait_strobe(got, ok);
    checks++;
    if (!ok || got !== ex(0, 0, 0, 40, 3)) begin
      errors++;
      $display("FAIL abort_4th got %h want %h", got,
               ex(0, 0, 0, 40, 3));
    end
    req_trk[6:0] = 7'd42;
    if (ok) ack_lba();
    for (int i = 0; i < 16; i++) begin
      xfer(got, ok);
      checks++;
      if (!ok || got !== ex(0, 0, 0, 42, i)) begin
        errors++;
        $display("FAIL abort_reload%0d got %h want %h", i, got,
                 ex(0, 0, 0, 42, i));
        if (!ok) break;
      end
      if (i == 0) begin
        checks++;
        if (n_done[0] !== d0) begin
          errors++;
          $display("FAIL abort_nodone got %0d want %0d",
                   n_done[0], d0);
        end
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok || n_done[0] !== d0 + 1 || cur_trk[6:0] !== 7'd42) begin
      errors++;
      $display("FAIL abort_end got %0d/%0d want %0d/42", n_done[0],
               cur_trk[6:0], d0 + 1);
    end
  endtask

  task automatic test_clamp;
    logic [33:0] got;
    bit ok;
    req_trk[13:7] = 7'd100;
    for (int i = 0; i < 16; i++) begin
      xfer(got, ok);
      checks++;
      if (!ok || got !== ex(0, 0, 1, 83, i)) begin
        errors++;
        $display("FAIL clamp_lba%0d got %h want %h", i, got,
                 ex(0, 0, 1, 83, i));
        if (!ok) break;
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok || cur_trk[13:7] !== 7'd83) begin
      errors++;
      $display("FAIL clamp_cur got %0d want 83", cur_trk[13:7]);
    end
  endtask

  task automatic test_reset_mid;
    logic [33:0] got;
    bit ok;
    int s;
    req_trk[13:7] = 7'd52;
    wait_strobe(got, ok);
    checks++;
    if (!ok || got !== ex(0, 0, 1, 52, 0)) begin
      errors++;
      $display("FAIL rmid_start got %h want %h", got,
               ex(0, 0, 1, 52, 0));
    end
    sd_ack = 1'b1;
    reset = 1'b1;
    req_trk = {7'd36, 7'd36};
    @(negedge sd_clk);
    checks++;
    if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
      errors++;
      $display("FAIL rmid_strobe got %b%b want 00", sd_rd, sd_wr);
    end
    checks++;
    if (busy !== 2'b00) begin
      errors++; $display("FAIL rmid_busy got %b want 00", busy);
    end
    reset = 1'b0;
    s = n_strobe;
    repeat (2) @(negedge sd_clk);
    sd_ack = 1'b0;
    repeat (10) @(negedge sd_clk);
    checks++;
    if (n_strobe !== s || busy !== 2'b00) begin
      errors++;
      $display("FAIL rmid_quiet got %0d/%b want %0d/00", n_strobe,
               busy, s);
    end
  endtask

  initial begin
    reset = 1'b1;
    sd_ack = 1'b0;
    req_trk = {7'd36, 7'd36};
    req_start = 8'h00;
    dirty = 2'b00;
    disk_change = 2'b00;
    test_reset();
    test_load();
    test_wb();
    test_rr(44, 46, 1'b0);
    test_meta();
    test_rr(48, 50, 1'b1);
    test_abort();
    test_clamp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
